// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_pkg
//  Purpose  : Shared widths, rounding-mode encoding and IEEE-754 single
//             special constants for the floating-point datapath blocks.
//  Revision : 1.0  initial release
// ============================================================================
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = 27;   // hidden bit + fraction + guard/round/sticky

    typedef enum logic [1:0] {
        RM_NEAREST = 2'd0,
        RM_ZERO    = 2'd1,
        RM_PINF    = 2'd2,
        RM_NINF    = 2'd3
    } rmode_t;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] INF_P   = 32'h7F80_0000;
    localparam logic [31:0] INF_N   = 32'hFF80_0000;
    localparam logic [31:0] MAX_FIN = 32'h7F7F_FFFF;

endpackage
`default_nettype wire

// File: rtl/fasu_lzc.sv
`default_nettype none
// ============================================================================
//  Module   : fasu_lzc
//  Purpose  : Combinational leading-zero counter for the 27-bit mantissa.
//             An all-zero input reports 27.
//  Ports    : value  in  27  word to examine
//             count  out  5  number of leading zeros above the first set bit
//  Revision : 1.0  initial release
// ============================================================================
module fasu_lzc (
    input  logic [26:0] value,
    output logic [4:0]  count
);

    // Ascending scan: the last set bit seen is the most significant one.
    always_comb begin
        count = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (value[i]) begin
                count = 5'(26 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fasu_post.sv
`default_nettype none
// ============================================================================
//  Module   : fasu_post
//  Purpose  : Add/subtract post-processing for single precision: aligned
//             mantissa add/sub (S1), normalisation (S2), round and pack (S3).
//             Three-stage pipeline with valid/ready flow control; a stall
//             freezes every stage together.
//  Ports    : clk, reset           clock, asynchronous active-high reset
//             in_valid / in_ready  operand handshake
//             rmode                rounding mode (rmode_t encoding)
//             fracta_in, fractb_in aligned mantissas, fracta_in >= fractb_in
//             exp_in               larger operand exponent
//             sign_in, fasu_op_in, zero_sign_in
//                                  result sign, 1=add, sign for exact zero
//             out_valid / out_ready result handshake
//             out_result           IEEE-754 single result
//             out_ine/ovf/unf/zero inexact, overflow, underflow, zero flags
//  Revision : 1.0  initial release
// ============================================================================
module fasu_post
    import fpu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          rmode,
    input  logic [MANT_W-1:0]   fracta_in,
    input  logic [MANT_W-1:0]   fractb_in,
    input  logic [EXP_W-1:0]    exp_in,
    input  logic                sign_in,
    input  logic                fasu_op_in,
    input  logic                zero_sign_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_result,
    output logic                out_ine,
    output logic                out_ovf,
    output logic                out_unf,
    output logic                out_zero
);

    // The whole pipe moves as one: a held output stalls everything upstream.
    logic w_adv;
    assign w_adv    = out_ready | ~out_valid;
    assign in_ready = w_adv;

    // ---------------- S1: add / subtract ----------------
    logic          r_v1, r_sign1, r_zsign1, r_inf1;
    logic [27:0]   r_sum1;
    logic [8:0]    r_e1;
    rmode_t        r_rm1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1     <= 1'b0;
            r_sum1   <= '0;
            r_e1     <= '0;
            r_sign1  <= 1'b0;
            r_zsign1 <= 1'b0;
            r_inf1   <= 1'b0;
            r_rm1    <= RM_NEAREST;
        end else if (w_adv) begin
            r_v1     <= in_valid;
            r_sum1   <= fasu_op_in ? ({1'b0, fracta_in} + {1'b0, fractb_in})
                                   : ({1'b0, fracta_in} - {1'b0, fractb_in});
            // Denormal inputs carry an effective exponent of 1.
            r_e1     <= (exp_in == '0) ? 9'd1 : {1'b0, exp_in};
            r_sign1  <= sign_in;
            r_zsign1 <= zero_sign_in;
            r_inf1   <= (exp_in == 8'hFF);
            r_rm1    <= rmode_t'(rmode);
        end
    end

    // ---------------- S2: normalise ----------------
    logic [4:0]    w_lz;
    logic [4:0]    w_shamt;
    logic [8:0]    w_emax;
    logic [26:0]   w_mant2;
    logic [8:0]    w_e2;

    fasu_lzc u_lzc (
        .value (r_sum1[26:0]),
        .count (w_lz)
    );

    always_comb begin
        w_shamt = 5'd0;
        w_emax  = r_e1 - 9'd1;
        w_mant2 = r_sum1[26:0];
        w_e2    = r_e1;
        if (r_sum1[27]) begin
            // Carry out: shift right one, keeping the dropped bit as sticky.
            w_mant2 = {r_sum1[27:2], r_sum1[1] | r_sum1[0]};
            w_e2    = r_e1 + 9'd1;
        end else begin
            // Never shift below exponent 1; anything left over is denormal.
            if ({4'd0, w_lz} < w_emax) begin
                w_shamt = w_lz;
            end else begin
                w_shamt = w_emax[4:0];
            end
            w_mant2 = r_sum1[26:0] << w_shamt;
            w_e2    = r_e1 - {4'd0, w_shamt};
        end
    end

    logic          r_v2, r_sign2, r_zsign2, r_inf2, r_zero2;
    logic [26:0]   r_mant2;
    logic [8:0]    r_e2;
    rmode_t        r_rm2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v2     <= 1'b0;
            r_mant2  <= '0;
            r_e2     <= '0;
            r_sign2  <= 1'b0;
            r_zsign2 <= 1'b0;
            r_inf2   <= 1'b0;
            r_zero2  <= 1'b0;
            r_rm2    <= RM_NEAREST;
        end else if (w_adv) begin
            r_v2     <= r_v1;
            r_mant2  <= w_mant2;
            r_e2     <= w_e2;
            r_sign2  <= r_sign1;
            r_zsign2 <= r_zsign1;
            r_inf2   <= r_inf1;
            r_zero2  <= (r_sum1 == '0);
            r_rm2    <= r_rm1;
        end
    end

    // ---------------- S3: round and pack ----------------
    logic          w_grs, w_inc, w_ine, w_ovf, w_unf, w_zero, w_to_inf;
    logic [24:0]   w_rnd;
    logic [9:0]    w_fexp;
    logic [31:0]   w_res;

    always_comb begin
        w_grs = |r_mant2[2:0];
        w_inc = 1'b0;
        unique case (r_rm2)
            RM_NEAREST: w_inc = r_mant2[2] & (r_mant2[1] | r_mant2[0] | r_mant2[3]);
            RM_ZERO:    w_inc = 1'b0;
            RM_PINF:    w_inc = ~r_sign2 & w_grs;
            RM_NINF:    w_inc =  r_sign2 & w_grs;
            default:    w_inc = 1'b0;
        endcase
        w_rnd = {1'b0, r_mant2[26:3]} + {24'd0, w_inc};
        // A denormal that rounds into bit 23 becomes exponent 1; a normal
        // that carries out of bit 23 bumps the exponent (fraction is zero).
        if (!r_mant2[26]) begin
            w_fexp = {9'd0, w_rnd[23]};
        end else begin
            w_fexp = {1'b0, r_e2} + {9'd0, w_rnd[24]};
        end
        w_to_inf = (r_rm2 == RM_NEAREST) | ((r_rm2 == RM_PINF) & ~r_sign2)
                 | ((r_rm2 == RM_NINF) & r_sign2);

        w_res  = {r_sign2, w_fexp[7:0], w_rnd[22:0]};
        w_ine  = w_grs;
        w_ovf  = 1'b0;
        w_unf  = (w_fexp == 10'd0) & w_grs;
        w_zero = (w_fexp == 10'd0) & (w_rnd[22:0] == '0);

        if (r_inf2) begin
            w_res  = {r_sign2, 8'hFF, 23'd0};
            w_ine  = 1'b0;
            w_unf  = 1'b0;
            w_zero = 1'b0;
        end else if (r_zero2) begin
            w_res  = {r_zsign2, 31'd0};
            w_ine  = 1'b0;
            w_unf  = 1'b0;
            w_zero = 1'b1;
        end else if (w_fexp >= 10'd255) begin
            w_res  = w_to_inf ? {r_sign2, INF_P[30:0]} : {r_sign2, MAX_FIN[30:0]};
            w_ine  = 1'b1;
            w_ovf  = 1'b1;
            w_unf  = 1'b0;
            w_zero = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_ine    <= 1'b0;
            out_ovf    <= 1'b0;
            out_unf    <= 1'b0;
            out_zero   <= 1'b0;
        end else if (w_adv) begin
            out_valid <= r_v2;
            if (r_v2) begin
                out_result <= w_res;
                out_ine    <= w_ine;
                out_ovf    <= w_ovf;
                out_unf    <= w_unf;
                out_zero   <= w_zero;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fasu_post.md
FASU_POST -- requirements
Module: fasu_post

Interface
REQ-001 SHALL have no parameters; field widths come from fpu_pkg: EXP_W=8, FRAC_W=23, MANT_W=27.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  in  1  input operand set valid.
REQ-005 SHALL have port in_ready  out  1  block accepts the operand set this cycle.
REQ-006 SHALL have port rmode  in  2  rounding mode: 0 nearest-even, 1 toward zero, 2 toward +inf, 3 toward -inf.
REQ-007 SHALL have port fracta_in  in  27  larger aligned mantissa: hidden bit [26], fraction [25:3], G/R/S [2:0].
REQ-008 SHALL have port fractb_in  in  27  smaller aligned mantissa, same layout, fracta_in >= fractb_in guaranteed.
REQ-009 SHALL have port exp_in  in  8  larger operand exponent (0 = denormal/zero).
REQ-010 SHALL have port sign_in, fasu_op_in, zero_sign_in  in  1 each  result sign, 1=add/0=subtract, sign to use for an exact-zero result.
REQ-011 SHALL have port out_valid  out  1  result valid; out_ready  in  1  consumer accepts.
REQ-012 SHALL have port out_result  out  32  IEEE-754 single result; out_ine, out_ovf, out_unf, out_zero  out  1 each  inexact, overflow, underflow, zero flags.

Function
REQ-013 SHALL implement a 3-stage pipeline: S1 add/sub, S2 normalize, S3 round/pack; latency 3 cycles from accepted input to out_valid with out_ready held high.
REQ-014 SHALL accept an input when in_valid & in_ready; in_ready = out_ready | !out_valid; a stall freezes all stages and their valid bits together.
REQ-015 SHALL hold out_result and all flags stable while out_valid & !out_ready.
REQ-016 S1 SHALL compute the 28-bit sum fracta_in+fractb_in when fasu_op_in=1, else fracta_in-fractb_in (never negative).
REQ-017 SHALL use effective exponent e = (exp_in==0) ? 1 : exp_in.
REQ-018 S2: if sum[27]=1, shift right 1 with bit 0 OR-ed into sticky and set e=e+1.
REQ-019 S2: otherwise take lz = leading zeros of sum[26:0] and shift left by min(lz, e-1); e = e - shift.
REQ-020 S2: if normalized bit [26]=0, the result SHALL be denormal with exponent field 0.
REQ-021 S3 SHALL round on G=[2], R=[1], S=[0].
REQ-022 S3 rounding increments: rmode 0 when G&(R|S|lsb); rmode 2 when !sign & (G|R|S); rmode 3 when sign & (G|R|S); rmode 1 never.
REQ-023 a rounding carry out of the mantissa SHALL increment the exponent; a denormal that rounds up to bit 23 set SHALL become exponent 1.
REQ-024 SHALL raise out_ovf=1 and out_ine=1 when the final exponent >= 255.
REQ-025 on overflow, result SHALL be infinity for rmode 0, for rmode 2 with sign 0, and for rmode 3 with sign 1; otherwise max finite 0x7F7FFFFF with the sign.
REQ-026 out_ine SHALL equal G|R|S after normalization; out_unf SHALL be 1 iff the result is denormal or zero and out_ine=1.
REQ-027 an exact-zero sum SHALL produce {zero_sign_in, 31'b0} with out_zero=1 and out_ine=0.
REQ-028 exp_in=255 SHALL yield {sign_in, 8'hFF, 23'b0}; NaN resolution is owned by the top-level exception unit.

Reset
REQ-029 on reset, SHALL clear all stage valid bits, out_valid=0, out_result=0 and all flags 0, with in_ready=1 on deassertion.
REQ-030 reset asserted mid-operation SHALL discard all in-flight results; no output is produced for them after release.

Structure
REQ-031 fpu_pkg SHALL hold the width constants, the rmode_t enum and the constants QNAN, INF_P, INF_N and MAX_FIN.
REQ-032 leading-zero counting SHALL be a sub-module fasu_lzc (27-bit in, 5-bit count out, combinational).

Verification
REQ-033 fracta=fractb=27'h4000000, exp=127, add, rmode 0 -> out_result 0x40000000 at cycle 3, all flags 0.
REQ-034 fracta=fractb=27'h4000000, exp=127, sub, zero_sign 0 -> 0x00000000, out_zero=1; zero_sign 1 -> 0x80000000.
REQ-035 fracta=fractb=27'h7FFFFF8, exp=254, add, sign 0: rmode 0 -> 0x7F800000, ovf=1, ine=1; rmode 1 -> 0x7F7FFFFF.
REQ-036 fracta=27'h4000004, fractb=0, exp=127, add, rmode 0 -> 0x3F800000, ine=1 (tie, even).
REQ-037 fracta=27'h4000004, fractb=0, exp=127, add, rmode 2 -> 0x3F800001.
REQ-038 4 back-to-back inputs with out_ready low cycles 2-5 -> in_ready low while stalled, all 4 results delivered in order, none lost or duplicated.
REQ-039 reset pulsed with 2 results in flight -> out_valid stays 0 until a new input is accepted, first output 3 cycles later.
